// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the 8085 control unit.
//   - enable-vector bit indices (IENB_*) driven towards the register/ALU block
//   - instruction-info field positions (INST_*) of the decoded chk_i word
//   - T-state encoding and bus status codes
//   - next_mcyc(): picks the next post-fetch machine cycle from the cycle mask
package core_pkg;

   localparam int IENBSIZE = 7;
   localparam int INSTSIZE = 17;
   localparam int CYCBITS  = 4;

   // ienb bit positions
   localparam int IENB_RRD = 0;
   localparam int IENB_RWR = 1;
   localparam int IENB_COD = 2;
   localparam int IENB_DAT = 3;
   localparam int IENB_PC  = 4;
   localparam int IENB_PD  = 5;
   localparam int IENB_NXT = 6;

   // chk_i field positions
   localparam int INST_GO6    = 0;
   localparam int INST_DAD    = 1;
   localparam int INST_HLT    = 2;
   localparam int INST_DIO    = 3;
   localparam int INST_CYC_LO = 4;
   localparam int INST_RW_LO  = 8;
   localparam int INST_CD_LO  = 12;
   localparam int INST_CCC    = 16;

   typedef enum logic [2:0] {
      TS_T1   = 3'd0,
      TS_T2   = 3'd1,
      TS_TW   = 3'd2,
      TS_T3   = 3'd3,
      TS_T4   = 3'd4,
      TS_T5   = 3'd5,
      TS_T6   = 3'd6,
      TS_THLT = 3'd7
   } tstate_e;

   // s1s0 status codes
   localparam logic [1:0] ST_FETCH = 2'b11;
   localparam logic [1:0] ST_READ  = 2'b10;
   localparam logic [1:0] ST_WRITE = 2'b01;
   localparam logic [1:0] ST_HALT  = 2'b00;

   // Mask bit j stands for machine cycle j+1 (M2 is mcyc 1). Returns the
   // lowest pending cycle strictly after cur, or 0 (back to M1) if none.
   function automatic logic [2:0] next_mcyc(input logic [CYCBITS-1:0] mask,
                                            input logic [2:0]         cur);
      logic [CYCBITS-1:0] above;
      logic [2:0]         r;
      above = mask & (4'b1111 << cur);
      casez (above)
         4'b???1: r = 3'd1;
         4'b??10: r = 3'd2;
         4'b?100: r = 3'd3;
         4'b1000: r = 3'd4;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/core_tstate.sv
// core_tstate: T-state register of the 8085 sequencer.
// Ports:
//   clk, rst_   clock and asynchronous active-low reset (reset state is T1)
//   ready       memory/IO ready, sampled in T2/TW
//   in_m1       current machine cycle is the opcode fetch (has T4..T6)
//   go6         instruction needs the idle T5/T6 states (looked at in T4)
//   halt_next   the cycle ending now is the last one and HLT was decoded
//   state       current T-state
module core_tstate
   import core_pkg::*;
(
   input  logic    clk,
   input  logic    rst_,
   input  logic    ready,
   input  logic    in_m1,
   input  logic    go6,
   input  logic    halt_next,
   output tstate_e state
);

   tstate_e state_d;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= TS_T1;
      else       state <= state_d;
   end

   // End of a machine cycle lands in T1 of the next one, or in THLT.
   always_comb begin
      state_d = state;
      case (state)
         TS_T1:   state_d = TS_T2;
         TS_T2:   state_d = ready ? TS_T3 : TS_TW;
         TS_TW:   state_d = ready ? TS_T3 : TS_TW;
         TS_T3:   state_d = in_m1 ? TS_T4 : (halt_next ? TS_THLT : TS_T1);
         TS_T4:   state_d = go6 ? TS_T5 : (halt_next ? TS_THLT : TS_T1);
         TS_T5:   state_d = TS_T6;
         TS_T6:   state_d = halt_next ? TS_THLT : TS_T1;
         TS_THLT: state_d = TS_THLT;
         default: state_d = TS_T1;
      endcase
   end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: machine-cycle sequencer / control unit of the 8085 core.
// Ports:
//   clk, rst_   clock and asynchronous active-low reset
//   chk_i       decoded instruction info (valid from M1 T4 onward)
//   i_cnd       instruction is conditional (Jccc/Cccc/Rccc)
//   ready       memory/IO ready
//   ienb        per-T-state enable pulses to the register/ALU block
//   ale, rd_, wr_, iom, s1s0, hlta   external bus strobes and status
//   mcyc        current machine cycle, 0 = M1 .. 4 = M5 (debug)
// Outputs are decoded from registered state, mcyc and the latched cycle
// mask only; ready reaches nothing but the next-state logic.
module core_ctrl
   import core_pkg::*;
(
   input  logic                clk,
   input  logic                rst_,
   input  logic [INSTSIZE-1:0] chk_i,
   input  logic                i_cnd,
   input  logic                ready,
   output logic [IENBSIZE-1:0] ienb,
   output logic                ale,
   output logic                rd_,
   output logic                wr_,
   output logic                iom,
   output logic [1:0]          s1s0,
   output logic                hlta,
   output logic [2:0]          mcyc
);

   tstate_e            state;
   logic [CYCBITS-1:0] mask;
   logic               hlt_q;

   logic [CYCBITS-1:0] cyc_f, rw_f, cd_f, new_mask, eff_mask;
   logic               in_m1, at_t4, eff_halt, cyc_end, halt_next;
   logic [2:0]         nxt;
   logic [1:0]         k;
   logic               rw_k, cd_k, strobe;
   logic               unused_ok;

   assign unused_ok = chk_i[INST_DAD];

   assign cyc_f = chk_i[INST_CYC_LO +: CYCBITS];
   assign rw_f  = chk_i[INST_RW_LO  +: CYCBITS];
   assign cd_f  = chk_i[INST_CD_LO  +: CYCBITS];

   assign in_m1 = (mcyc == 3'd0);
   assign at_t4 = (state == TS_T4);

   // A failed condition keeps only M2 (the Rccc-style extra); Jccc sets CCC
   // so its operand fetches still run.
   always_comb begin
      new_mask = cyc_f;
      if (i_cnd && !chk_i[INST_CCC]) new_mask = cyc_f & 4'b0001;
   end

   // The mask and halt flag are latched on the T4 edge, so the T4 decision
   // has to look at the values being latched rather than the old ones.
   assign eff_mask  = at_t4 ? new_mask : mask;
   assign eff_halt  = at_t4 ? chk_i[INST_HLT] : hlt_q;
   assign nxt       = next_mcyc(eff_mask, mcyc);
   assign halt_next = eff_halt && (nxt == 3'd0);
   assign cyc_end   = ((state == TS_T3) && !in_m1) ||
                      (at_t4 && !chk_i[INST_GO6]) ||
                      (state == TS_T6);

   core_tstate u_tstate (
      .clk       (clk),
      .rst_      (rst_),
      .ready     (ready),
      .in_m1     (in_m1),
      .go6       (chk_i[INST_GO6]),
      .halt_next (halt_next),
      .state     (state)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mcyc  <= 3'd0;
         mask  <= '0;
         hlt_q <= 1'b0;
      end else begin
         if (at_t4) begin
            mask  <= new_mask;
            hlt_q <= chk_i[INST_HLT];
         end
         if (cyc_end) mcyc <= nxt;
      end
   end

   // k indexes the RW/CD fields: M2 -> 0 .. M5 -> 3
   assign k      = 2'(mcyc - 3'd1);
   assign rw_k   = rw_f[k];
   assign cd_k   = cd_f[k];
   assign strobe = (state == TS_T2) || (state == TS_TW) || (state == TS_T3);

   always_comb begin
      ale  = 1'b0;
      rd_  = 1'b1;
      wr_  = 1'b1;
      iom  = 1'b0;
      s1s0 = ST_FETCH;
      hlta = 1'b0;
      ienb = '0;
      if (state == TS_THLT) begin
         s1s0 = ST_HALT;
         hlta = 1'b1;
      end else if (in_m1) begin
         ale = (state == TS_T1);
         rd_ = !strobe;
         if (state == TS_T3) begin
            ienb[IENB_COD] = 1'b1;
            ienb[IENB_PC]  = 1'b1;
         end
         if (at_t4 && (cyc_f == 4'd0)) begin
            ienb[IENB_RRD] = 1'b1;
            ienb[IENB_RWR] = 1'b1;
         end
      end else begin
         ale            = (state == TS_T1);
         s1s0           = rw_k ? ST_WRITE : ST_READ;
         iom            = chk_i[INST_DIO] && (mcyc == 3'd2);
         ienb[IENB_PD]  = cd_k;
         ienb[IENB_NXT] = ~k[0];
         if (strobe) begin
            if (rw_k) begin
               wr_            = 1'b0;
               ienb[IENB_RRD] = 1'b1;
            end else begin
               rd_ = 1'b0;
            end
         end
         if (state == TS_T3) begin
            if (rw_k) begin
               ienb[IENB_DAT] = cd_k;
            end else begin
               ienb[IENB_RWR] = 1'b1;
               ienb[IENB_PC]  = !cd_k;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed bench for core_ctrl. Each instruction is expanded
// into its machine cycles and T-states from the cycle mask; every clock gets
// an expected bus/enable word that a single compare process checks.
module tb_core_ctrl;
   import core_pkg::*;

   localparam int W = 17;
   localparam int L_T1 = 1, L_T2 = 2, L_TW = 3, L_T3 = 4, L_T4 = 5,
                  L_T5 = 6, L_T6 = 7, L_THLT = 8;

   logic                clk = 1'b0;
   logic                rst_;
   logic [INSTSIZE-1:0] chk_i;
   logic                i_cnd;
   logic                ready;
   logic [IENBSIZE-1:0] ienb;
   logic                ale, rd_, wr_, iom, hlta;
   logic [1:0]          s1s0;
   logic [2:0]          mcyc;

   int n_cmp = 0;
   int n_bad = 0;
   int clk_cnt = 0;
   int step_no = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   int           lbl_q[$];
   logic [W-1:0] got_w, exp_w, msk_w;
   int           lbl_w;

   core_ctrl dut (
      .clk   (clk),
      .rst_  (rst_),
      .chk_i (chk_i),
      .i_cnd (i_cnd),
      .ready (ready),
      .ienb  (ienb),
      .ale   (ale),
      .rd_   (rd_),
      .wr_   (wr_),
      .iom   (iom),
      .s1s0  (s1s0),
      .hlta  (hlta),
      .mcyc  (mcyc)
   );

   // clock
   always #5 clk = ~clk;

   assign got_w = {ale, rd_, wr_, iom, s1s0, hlta, mcyc, ienb};

   function automatic logic [INSTSIZE-1:0] mk(input logic go6, input logic hlt,
      input logic dio, input logic [3:0] cyc, input logic [3:0] rw,
      input logic [3:0] cd, input logic ccc);
      return {ccc, cd, rw, cyc, dio, hlt, 1'b0, go6};
   endfunction

   // Expected outputs for T-state label lbl of machine cycle m (0 = M1).
   function automatic logic [W-1:0] model_out(input int lbl, input int m,
                                              input logic [INSTSIZE-1:0] c);
      logic       e_ale, e_rd, e_wr, e_iom, rw, cd, strb;
      logic [1:0] e_s;
      logic [6:0] e_en;
      int         kk;
      e_ale = (lbl == L_T1);
      e_rd = 1'b1; e_wr = 1'b1; e_iom = 1'b0; e_en = '0;
      strb = (lbl == L_T2) || (lbl == L_TW) || (lbl == L_T3);
      if (lbl == L_THLT)
         return {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd0, 7'd0};
      if (m == 0) begin
         e_s = 2'b11;
         if (strb) e_rd = 1'b0;
         if (lbl == L_T3) begin e_en[IENB_COD] = 1'b1; e_en[IENB_PC] = 1'b1; end
         if (lbl == L_T4 && c[7:4] == 4'd0) begin
            e_en[IENB_RRD] = 1'b1; e_en[IENB_RWR] = 1'b1;
         end
      end else begin
         kk = m - 1;
         rw = c[8 + kk];
         cd = c[12 + kk];
         e_s = rw ? 2'b01 : 2'b10;
         e_iom = c[3] && (m == 2);
         e_en[IENB_PD]  = cd;
         e_en[IENB_NXT] = (kk % 2 == 0);
         if (strb && rw)  begin e_wr = 1'b0; e_en[IENB_RRD] = 1'b1; end
         if (strb && !rw) e_rd = 1'b0;
         if (lbl == L_T3 && rw) e_en[IENB_DAT] = cd;
         if (lbl == L_T3 && !rw) begin
            e_en[IENB_RWR] = 1'b1; e_en[IENB_PC] = !cd;
         end
      end
      return {e_ale, e_rd, e_wr, e_iom, e_s, 1'b0, 3'(m), e_en};
   endfunction

   // Queue the expectation for the current T-state, set ready for the
   // coming edge, then advance one clock.
   task automatic step(input int lbl, input int m, input logic rdy);
      exp_q.push_back(model_out(lbl, m, chk_i));
      // mcyc is not meaningful while halted
      msk_q.push_back(lbl == L_THLT ? 17'h1FC7F : 17'h1FFFF);
      lbl_q.push_back(lbl);
      ready = rdy;
      clk_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_cycle(input int m, input int waits);
      step(L_T1, m, 1'b1);
      step(L_T2, m, waits == 0);
      for (int i = 0; i < waits; i++) step(L_TW, m, i == waits - 1);
      step(L_T3, m, 1'b1);
      if (m == 0) begin
         step(L_T4, m, 1'b1);
         if (chk_i[INST_GO6]) begin
            step(L_T5, m, 1'b1);
            step(L_T6, m, 1'b1);
         end
      end
   endtask

   task automatic run_instr(input logic [INSTSIZE-1:0] c, input logic cnd,
                            input int waits, output int clocks);
      logic [3:0] msk;
      chk_i = c;
      i_cnd = cnd;
      clk_cnt = 0;
      msk = (cnd && !c[INST_CCC]) ? {3'b000, c[4]} : c[7:4];
      do_cycle(0, waits);
      for (int n = 1; n <= 4; n++)
         if (msk[n-1]) do_cycle(n, 0);
      clocks = clk_cnt;
   endtask

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // scoreboard: one compare per queued expectation, mid-clock
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         msk_w = msk_q.pop_front();
         lbl_w = lbl_q.pop_front();
         step_no++;
         n_cmp++;
         if ((got_w & msk_w) !== (exp_w & msk_w)) begin
            n_bad++;
            $display("FAIL step%0d lbl%0d: got %h want %h", step_no, lbl_w,
                     got_w, exp_w);
         end
      end
   end

   initial begin
      int clocks;
      rst_ = 1'b0; ready = 1'b1; chk_i = '0; i_cnd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_word", 32'(got_w),
            32'({1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 3'd0, 7'd0}));
      @(posedge clk);
      #1;
      rst_ = 1'b1;

      // MOV B,C
      run_instr(mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), 1'b0, 0, clocks);
      check("movbc_clocks", clocks, 4);
      check("movbc_next_ale", 32'(ale), 1);
      // MVI B
      run_instr(mk(0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0), 1'b0, 0, clocks);
      check("mvi_clocks", clocks, 7);
      // MOV M,A
      run_instr(mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 0), 1'b0, 0, clocks);
      check("movma_clocks", clocks, 7);
      // two wait states in the fetch
      run_instr(mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), 1'b0, 2, clocks);
      check("wait_clocks", clocks, 6);
      // OUT port
      run_instr(mk(0, 0, 1, 4'b0011, 4'b0010, 4'b0010, 0), 1'b0, 0, clocks);
      check("out_clocks", clocks, 10);
      // conditional, condition false / true
      run_instr(mk(0, 0, 0, 4'b0011, 4'b0000, 4'b0000, 0), 1'b1, 0, clocks);
      check("ccc0_clocks", clocks, 7);
      run_instr(mk(0, 0, 0, 4'b0011, 4'b0000, 4'b0000, 1), 1'b1, 0, clocks);
      check("ccc1_clocks", clocks, 10);
      // six-state fetch
      run_instr(mk(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), 1'b0, 0, clocks);
      check("go6_clocks", clocks, 6);
      // HLT with one extra read cycle, then hold in THLT
      run_instr(mk(0, 1, 0, 4'b0001, 4'b0000, 4'b0000, 0), 1'b0, 0, clocks);
      check("hlt_clocks", clocks, 7);
      for (int i = 0; i < 20; i++) step(L_THLT, 0, 1'b1);
      check("thlt_hlta", 32'(hlta), 1);
      // asynchronous reset in the middle of THLT
      #2;
      rst_ = 1'b0;
      #1;
      check("rst_hlta", 32'(hlta), 0);
      check("rst_ale", 32'(ale), 1);
      check("rst_s1s0", 32'(s1s0), 32'h3);
      check("rst_mcyc", 32'(mcyc), 0);
      @(posedge clk);
      #1;
      rst_ = 1'b1;
      run_instr(mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0), 1'b0, 0, clocks);
      check("resume_clocks", clocks, 4);
      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- T-state / machine-cycle sequencer for the 8085 core; it is the control unit that consumes the alureg instruction-info word (chk_i) and drives its enable vector (ienb).
- Generates external bus strobes (ale, rd_, wr_, iom, s1/s0, hlta) and the per-T-state ienb pulses for opcode fetch, memory/IO read and write cycles, wait states and halt.

Parameters:
- IENBSIZE, 7, width of ienb; bit indices RRD=0 RWR=1 COD=2 DAT=3 PC_=4 PD_=5 NXT=6
- INSTSIZE, 17, width of chk_i; GO6=0 DAD=1 HLT=2 DIO=3 CYC=7:4 RW=11:8 CD=15:12 CCC=16
- CYCBITS, 4, number of post-fetch machine cycles (M2..M5)

Ports:
- clk  in  1  system clock, rising edge
- rst_  in  1  asynchronous active-low reset
- chk_i  in  INSTSIZE  decoded instruction info; valid from T4 of M1 onward
- i_cnd  in  1  current instruction is conditional (Jccc/Cccc/Rccc)
- ready  in  1  memory/IO ready, sampled in T2/TW
- ienb  out  IENBSIZE  enable pulses to the register/ALU block
- ale  out  1  address latch enable
- rd_  out  1  read strobe, active low
- wr_  out  1  write strobe, active low
- iom  out  1  1 = IO cycle, 0 = memory cycle
- s1s0  out  2  cycle status: 11 fetch, 10 read, 01 write, 00 halt
- hlta  out  1  halt acknowledge
- mcyc  out  3  current machine cycle, 0 = M1 .. 4 = M5 (debug)

Behaviour:
- States: T1, T2, TW, T3, T4, T5, T6, THLT. Registered state and mcyc. All outputs decode from registered state/mcyc/latched mask (Moore); no combinational path from ready.
- Reset (async, rst_=0): state=T1, mcyc=0, mask=0. Outputs during reset: ale=1, s1s0=11, rd_=1, wr_=1, iom=0, hlta=0, ienb=0.
- M1 (opcode fetch):
  - T1: ale=1, s1s0=11.
  - T2: rd_=0. If ready=0 go to TW, else go to T3.
  - TW: rd_=0; stay while ready=0.
  - T3: rd_=0, COD=1 and PC_=1 (opcode latched and PC increments on the T3 edge).
  - T4: chk_i is sampled.
    - mask <= CYC.
    - If i_cnd=1 and CCC=0, mask <= CYC & 4'b0001: only M2 survives for Rccc-style one-cycle extras; for Jccc the operand-fetch cycles still run.
    - If CYC==0: RRD=1, RWR=1 (single-cycle register transfer).
    - Next state: T5 if GO6=1, else T1 of the next cycle.
  - T5 and T6 are idle, with ienb=0.
- Next cycle selection: the lowest set bit of mask above the current cycle. If none remain, return to M1 (or THLT if HLT latched at T4). Cycles run in order M2..M5 with no gaps, because the mask is contiguous.
- Mn, n=2..5, k=n-2:
  - T1: ale=1. s1s0=01 if RW[k] else 10. iom=DIO & (n==3).
  - PD_=CD[k] for T1..T3. NXT=~k[0] (low byte on even k).
  - T2: rd_=0 (read) or wr_=0 (write). ready handling is the same as in M1.
  - Read cycle: T3 asserts RWR. When CD[k]=0, T3 also asserts PC_.
  - Write cycle: RRD is asserted in T2, TW and T3. RW[k]=1 together with CD[k]=1 also asserts DAT in T3.
- HLT: after the final cycle, enter THLT. Outputs in THLT: hlta=1, s1s0=00, ale=0, rd_=wr_=1, ienb=0. Exit only by reset.
- rd_ and wr_ are never low simultaneously. ale is high only in T1. PC_ is never asserted when PD_=1.
- Reset mid-cycle aborts immediately; the next fetch restarts at T1/M1.

Decomposition:
- Shared package core_pkg holds:
  - IENB_* and INST_* bit indices
  - T-state encoding
  - status codes
- Natural sub-module: core_tstate, the T1..T6/TW/THLT state register with ready/GO6/halt transitions.
- The core_ctrl top level owns mcyc, the mask latch, cycle selection and output decode.

Test Plan:
- MOV B,C (CYC=0, GO6=0), ready=1: 4 clocks T1-T4. COD and PC_ pulse in T3; RRD and RWR pulse in T4; ale is back high on clock 5.
- MVI B (CYC=0001, RW=0, CD=0): 7 clocks. M2 has s1s0=10, NXT=1, rd_ low in T2-T3, RWR and PC_ in T3, PD_=0 throughout.
- MOV M,A (CYC=0001, RW=0001, CD=0001): M2 has s1s0=01, PD_=1 for T1-T3, wr_ low in T2-T3, RRD in T2-T3, DAT in T3, PC_ never.
- ready=0 for 2 clocks in M1 T2: sequence is T1,T2,TW,TW,T3,T4 (6 clocks) with rd_ held low through both TW states. OUT (DIO=1, CYC=0011, RW=0010): iom=1 only in M3.
- Conditional, CYC=0011, i_cnd=1, CCC=0: only M2 runs (7 clocks). The same instruction with CCC=1 runs M2 and M3 (10 clocks).
- HLT (HLT=1, CYC=0001): after M2, THLT with hlta=1, s1s0=00, no ale for 20 clocks. Dropping rst_ mid-THLT gives state T1, hlta=0 asynchronously; the next fetch resumes.
